// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP slice MAC sequencer.
// Latency helpers derive pipeline depth from the slice register options.
// No flow control lives here; constants and pure functions only.
package dsp_ctrl_pkg;

  // Sequencer state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_ABRT  = 3'd4;

  // Input-stage latency: the slower of the A and B register paths.
  function automatic int calc_la(input int areg, input int breg);
    return (areg > breg) ? areg : breg;
  endfunction

  // Total cycles from an accepted beat until its product is folded into P.
  function automatic int calc_d(input int areg, input int breg,
                                input int mreg, input int preg);
    return calc_la(areg, breg) + mreg + preg;
  endfunction

  // DONE can never coincide with the accepting cycle, so it waits at least one.
  function automatic int done_delay(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/dsp_mac_ctrl_pipe.sv
// Token shift register that follows each accepted beat through the slice pipe.
// Latency: CEM/CEP taps fire LA / LA+MREG cycles after accept; last flag exits after DEPTH.
// No backpressure: tokens advance every cycle; flush clears every stage at once.
module dsp_token_pipe #(
  parameter int DEPTH   = 3,
  parameter int CEM_TAP = 1,
  parameter int CEP_TAP = 2,
  parameter int USE_CEM = 1,
  parameter int USE_CEP = 1
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic accept_i,
  input  logic last_i,
  input  logic flush_i,
  output logic cem_o,
  output logic cep_o,
  output logic last_exit_o
);

  // Stage i holds a token that was accepted i+1 cycles ago.
  logic [DEPTH-1:0] tok_q, tok_d;
  logic [DEPTH-1:0] last_q, last_d;

  // Shift every cycle; the last-beat tag travels with its token.
  always_comb begin
    tok_d  = '0;
    last_d = '0;
    if (!flush_i) begin
      tok_d[0]  = accept_i;
      last_d[0] = accept_i & last_i;
      for (int i = 1; i < DEPTH; i++) begin
        tok_d[i]  = tok_q[i-1];
        last_d[i] = last_q[i-1];
      end
    end
  end

  // Pipe registers, cleared on reset so no stale enables survive.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tok_q  <= '0;
      last_q <= '0;
    end else begin
      tok_q  <= tok_d;
      last_q <= last_d;
    end
  end

  // Tap 0 means the stage enable coincides with the accepting cycle.
  generate
    if (USE_CEM == 0) begin : g_no_cem
      assign cem_o = 1'b0;
    end else if (CEM_TAP == 0) begin : g_cem_now
      assign cem_o = accept_i;
    end else begin : g_cem_tap
      assign cem_o = tok_q[CEM_TAP-1];
    end

    if (USE_CEP == 0) begin : g_no_cep
      assign cep_o = 1'b0;
    end else if (CEP_TAP == 0) begin : g_cep_now
      assign cep_o = accept_i;
    end else begin : g_cep_tap
      assign cep_o = tok_q[CEP_TAP-1];
    end
  endgenerate

  // The final product is visible once its tagged token leaves the last stage.
  assign last_exit_o = tok_q[DEPTH-1] & last_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequencer for a DSP slice multiply-accumulate burst of LEN beats into P.
// Latency: CLEAR takes 1 cycle; DONE pulses max(D,1) cycles after the last accept.
// Backpressure: IN_READY high only in FEED; IN_VALID low inserts bubbles, ABORT cancels.
module dsp_mac_ctrl #(
  parameter int AREG  = 1,
  parameter int BREG  = 1,
  parameter int MREG  = 1,
  parameter int PREG  = 1,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ABORT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             CEA,
  output logic             CEB,
  output logic             CEM,
  output logic             CEP,
  output logic             RSTP,
  output logic             BUSY,
  output logic             DONE
);

  import dsp_ctrl_pkg::*;

  localparam int LA = calc_la(AREG, BREG);
  localparam int D  = calc_d(AREG, BREG, MREG, PREG);
  localparam int DD = done_delay(D);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic in_ready_c, accept_c, last_beat_c, flush_c;
  logic cea_c, ceb_c, cem_c, cep_c, rstp_c, busy_c, done_c;
  logic pipe_cem, pipe_cep, pipe_last;

  // Handshake and abort decode, kept outside the FSM block so the
  // zero-latency pipe taps do not form a combinational loop through it.
  assign in_ready_c  = (state_q == ST_FEED) && !ABORT;
  assign accept_c    = in_ready_c && IN_VALID;
  assign last_beat_c = accept_c && (cnt_q == len_q - LEN_W'(1));
  assign flush_c     = ABORT && ((state_q == ST_CLEAR) ||
                                 (state_q == ST_FEED)  ||
                                 (state_q == ST_DRAIN));

  dsp_token_pipe #(
    .DEPTH  (DD),
    .CEM_TAP(LA),
    .CEP_TAP(LA + MREG),
    .USE_CEM(MREG),
    .USE_CEP(PREG)
  ) u_pipe (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .accept_i   (accept_c),
    .last_i     (last_beat_c),
    .flush_i    (flush_c),
    .cem_o      (pipe_cem),
    .cep_o      (pipe_cep),
    .last_exit_o(pipe_last)
  );

  // Next-state and slice-control decode; an abort cycle drives no enables.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cea_c   = 1'b0;
    ceb_c   = 1'b0;
    cem_c   = 1'b0;
    cep_c   = 1'b0;
    rstp_c  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          len_d   = LEN;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy_c = 1'b1;
        if (ABORT) begin
          state_d = ST_ABRT;
        end else begin
          // P sits behind a gated clock, so its reset needs CEP too.
          rstp_c  = 1'b1;
          cep_c   = 1'b1;
          state_d = (len_q != '0) ? ST_FEED : ST_DRAIN;
        end
      end
      ST_FEED: begin
        busy_c = 1'b1;
        if (ABORT) begin
          state_d = ST_ABRT;
        end else begin
          cem_c = pipe_cem;
          cep_c = pipe_cep;
          if (accept_c) begin
            cea_c = (AREG != 0);
            ceb_c = (BREG != 0);
            cnt_d = cnt_q + LEN_W'(1);
            if (last_beat_c) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        busy_c = 1'b1;
        if (ABORT) begin
          state_d = ST_ABRT;
        end else begin
          cem_c = pipe_cem;
          cep_c = pipe_cep;
          // An empty burst has no token to wait for; DONE follows CLEAR directly.
          if ((len_q == '0) || pipe_last) begin
            done_c  = 1'b1;
            busy_c  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ABRT: begin
        // Leave P cleared so a cancelled burst never looks like a result.
        rstp_c  = 1'b1;
        cep_c   = 1'b1;
        busy_c  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, latched length and beat counter; reset returns to IDLE.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold every output low while reset is asserted, even before the first edge.
  assign IN_READY = RSTN & in_ready_c;
  assign CEA      = RSTN & cea_c;
  assign CEB      = RSTN & ceb_c;
  assign CEM      = RSTN & cem_c;
  assign CEP      = RSTN & cep_c;
  assign RSTP     = RSTN & rstp_c;
  assign BUSY     = RSTN & busy_c;
  assign DONE     = RSTN & done_c;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
module tb_dsp_mac_ctrl;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RSTN, START, ABORT, IN_VALID;
  logic [7:0] LEN;
  logic       IN_READY, CEA, CEB, CEM, CEP, RSTP, BUSY, DONE;

  logic       z_start, z_valid;
  logic [7:0] z_len;
  logic       z_ready, z_cea, z_ceb, z_cem, z_cep, z_rstp, z_busy, z_done;

  dsp_mac_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN), .ABORT(ABORT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .CEA(CEA), .CEB(CEB),
    .CEM(CEM), .CEP(CEP), .RSTP(RSTP), .BUSY(BUSY), .DONE(DONE)
  );

  dsp_mac_ctrl #(.AREG(0), .BREG(0), .MREG(0), .PREG(0), .LEN_W(8)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .START(z_start), .LEN(z_len), .ABORT(1'b0),
    .IN_VALID(z_valid), .IN_READY(z_ready), .CEA(z_cea), .CEB(z_ceb),
    .CEM(z_cem), .CEP(z_cep), .RSTP(z_rstp), .BUSY(z_busy), .DONE(z_done)
  );

  logic [7:0] obs_now, z_obs;
  assign obs_now = {IN_READY, CEA, CEB, CEM, CEP, RSTP, BUSY, DONE};
  assign z_obs   = {z_ready, z_cea, z_ceb, z_cem, z_cep, z_rstp, z_busy, z_done};

  // Behavioural DSP slice driven by the controller's enables.
  logic [7:0]  a_in, b_in, a_r, b_r;
  logic [15:0] m_r;
  logic [31:0] p_r = 32'd0;
  always @(posedge CLK) begin
    if (CEA) a_r <= a_in;
    if (CEB) b_r <= b_in;
    if (CEM) m_r <= a_r * b_r;
    if (CEP) p_r <= RSTP ? 32'd0 : p_r + 32'(m_r);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle stimulus and expectations; cycle 0 is the IDLE cycle with START.
  bit         st_in[64], ab_in[64], vl_in[64];
  logic [7:0] a_arr[64], b_arr[64];
  bit         e_rdy[64], e_cea[64], e_ceb[64], e_cem[64], e_cep[64];
  bit         e_rstp[64], e_busy[64], e_done[64];
  logic [7:0] obs[64];

  function automatic void clear_stim();
    for (int k = 0; k < 64; k++) begin
      st_in[k] = 0; ab_in[k] = 0; vl_in[k] = 0;
      a_arr[k] = 8'($urandom_range(0, 255));
      b_arr[k] = 8'($urandom_range(0, 255));
    end
  endfunction

  // Reference: CLEAR at 1, FEED from 2 accepting while valid, CEM at a+1,
  // CEP at a+2, DONE at last+3; abort blanks the cycle then one ABRT cycle.
  function automatic int build_expect(input int len, input int abort_at);
    int acc  = 0;
    int last = -1;
    int done = -1;
    for (int k = 0; k < 64; k++) begin
      e_rdy[k] = 0; e_cea[k] = 0; e_ceb[k] = 0; e_cem[k] = 0;
      e_cep[k] = 0; e_rstp[k] = 0; e_busy[k] = 0; e_done[k] = 0;
    end
    e_rstp[1] = 1; e_cep[1] = 1; e_busy[1] = 1;
    if (len == 0) begin
      done = 2;
    end else begin
      for (int k = 2; k < 58 && acc < len; k++) begin
        e_rdy[k] = 1; e_busy[k] = 1;
        if (vl_in[k]) begin
          e_cea[k] = 1; e_ceb[k] = 1; e_cem[k+1] = 1; e_cep[k+2] = 1;
          acc++;
          if (acc == len) last = k;
        end
      end
      if (last >= 0) begin
        e_busy[last+1] = 1; e_busy[last+2] = 1;
        done = last + 3;
      end
    end
    if (done >= 0) e_done[done] = 1;
    if (abort_at >= 0) begin
      for (int k = abort_at; k < 64; k++) begin
        e_rdy[k] = 0; e_cea[k] = 0; e_ceb[k] = 0; e_cem[k] = 0;
        e_cep[k] = 0; e_rstp[k] = 0; e_busy[k] = 0; e_done[k] = 0;
      end
      e_busy[abort_at] = 1;
      e_rstp[abort_at+1] = 1; e_cep[abort_at+1] = 1; e_busy[abort_at+1] = 1;
      done = -1;
    end
    return done;
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    return {e_rdy[k], e_cea[k], e_ceb[k], e_cem[k], e_cep[k], e_rstp[k], e_busy[k], e_done[k]};
  endfunction

  function automatic logic [31:0] exp_p(input bit aborted);
    logic [31:0] s = 32'd0;
    if (!aborted)
      for (int k = 0; k < 64; k++)
        if (e_cea[k]) s = s + 32'(a_arr[k]) * 32'(b_arr[k]);
    return s;
  endfunction

  task automatic drive_trace(input int n);
    for (int k = 0; k < n; k++) begin
      START = st_in[k]; ABORT = ab_in[k]; IN_VALID = vl_in[k];
      a_in = a_arr[k]; b_in = b_arr[k];
      @(negedge CLK);
      obs[k] = obs_now;
      @(posedge CLK); #1;
    end
    START = 0; ABORT = 0; IN_VALID = 0;
  endtask

  task automatic test_reset();
    RSTN = 0; START = 1; ABORT = 0; IN_VALID = 1; LEN = 8'd3;
    z_start = 0; z_valid = 0; z_len = 0; a_in = 0; b_in = 0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({obs_now, z_obs} !== 16'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0000", {obs_now, z_obs});
    end
    @(posedge CLK); #1;
    RSTN = 1; START = 0; IN_VALID = 0;
    @(negedge CLK);
    n_cmp++;
    if (obs_now !== 8'h00) begin
      n_bad++; $display("FAIL reset_idle: got %b required 00000000", obs_now);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_len4_stream();
    int done;
    clear_stim();
    st_in[0] = 1; LEN = 8'd4;
    for (int k = 0; k < 64; k++) vl_in[k] = 1;
    done = build_expect(4, -1);
    drive_trace(done + 1);
    for (int k = 0; k <= done; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++; $display("FAIL len4 cycle %0d: got %b required %b", k, obs[k], exp_vec(k));
      end
    end
    n_cmp++;
    if (p_r !== exp_p(0)) begin
      n_bad++; $display("FAIL len4_p: got %0d required %0d", p_r, exp_p(0));
    end
  endtask

  task automatic test_len3_gaps();
    int done;
    clear_stim();
    st_in[0] = 1; LEN = 8'd3;
    vl_in[2] = 1; vl_in[3] = 0; vl_in[4] = 1; vl_in[5] = 0; vl_in[6] = 1;
    done = build_expect(3, -1);
    drive_trace(done + 1);
    for (int k = 0; k <= done; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++; $display("FAIL len3_gaps cycle %0d: got %b required %b", k, obs[k], exp_vec(k));
      end
    end
    n_cmp++;
    if (p_r !== exp_p(0)) begin
      n_bad++; $display("FAIL len3_gaps_p: got %0d required %0d", p_r, exp_p(0));
    end
  endtask

  task automatic test_len0();
    int done;
    clear_stim();
    st_in[0] = 1; LEN = 8'd0;
    for (int k = 0; k < 64; k++) vl_in[k] = 1;
    done = build_expect(0, -1);
    drive_trace(done + 1);
    for (int k = 0; k <= done; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++; $display("FAIL len0 cycle %0d: got %b required %b", k, obs[k], exp_vec(k));
      end
    end
    n_cmp++;
    if (p_r !== 32'd0) begin
      n_bad++; $display("FAIL len0_p: got %0d required 0", p_r);
    end
  endtask

  task automatic test_abort();
    int tmp;
    clear_stim();
    st_in[0] = 1; LEN = 8'd5;
    for (int k = 0; k < 64; k++) vl_in[k] = 1;
    ab_in[4] = 1;
    tmp = build_expect(5, 4);
    drive_trace(6);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++; $display("FAIL abort cycle %0d: got %b required %b", k, obs[k], exp_vec(k));
      end
    end
    n_cmp++;
    if (p_r !== 32'd0 || tmp !== -1) begin
      n_bad++; $display("FAIL abort_p: got %0d required 0", p_r);
    end
    // ABORT beats a simultaneous START in IDLE.
    START = 1; ABORT = 1; LEN = 8'd2;
    @(posedge CLK); #1;
    START = 0; ABORT = 0;
    @(negedge CLK);
    n_cmp++;
    if (obs_now !== 8'h00) begin
      n_bad++; $display("FAIL abort_wins_idle: got %b required 00000000", obs_now);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_zero_regs();
    logic [7:0] zexp[6];
    zexp[0] = 8'b0000_0000; zexp[1] = 8'b0000_1110; zexp[2] = 8'b1000_0010;
    zexp[3] = 8'b1000_0010; zexp[4] = 8'b0000_0001; zexp[5] = 8'b0000_0000;
    z_len = 8'd2; z_valid = 1;
    for (int k = 0; k < 6; k++) begin
      z_start = (k == 0);
      @(negedge CLK);
      n_cmp++;
      if (z_obs !== zexp[k]) begin
        n_bad++; $display("FAIL zero_regs cycle %0d: got %b required %b", k, z_obs, zexp[k]);
      end
      @(posedge CLK); #1;
    end
    z_start = 0; z_valid = 0;
  endtask

  task automatic test_rst_drain();
    int done;
    clear_stim();
    st_in[0] = 1; LEN = 8'd2;
    for (int k = 0; k < 64; k++) vl_in[k] = 1;
    done = build_expect(2, -1);
    drive_trace(4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs[k] !== exp_vec(k)) begin
        n_bad++; $display("FAIL rst_drain_pre cycle %0d: got %b required %b", k, obs[k], exp_vec(k));
      end
    end
    RSTN = 0; START = 1; IN_VALID = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (obs_now !== 8'h00) begin
        n_bad++; $display("FAIL rst_drain_low %0d: got %b required 00000000", k, obs_now);
      end
      @(posedge CLK); #1;
    end
    RSTN = 1; LEN = 8'd1;
    @(negedge CLK);
    n_cmp++;
    if (obs_now !== 8'h00) begin
      n_bad++; $display("FAIL rst_release_idle: got %b required 00000000", obs_now);
    end
    @(posedge CLK); #1;
    START = 0;
    @(negedge CLK);
    n_cmp++;
    if (obs_now !== 8'b0000_1110) begin
      n_bad++; $display("FAIL rst_release_start: got %b required 00001110 (done ref %0d)", obs_now, done);
    end
    repeat (6) @(posedge CLK);
    #1;
    IN_VALID = 0;
  endtask

  task automatic test_back_to_back();
    int len, done, abort_at, n;
    for (int r = 0; r < 10; r++) begin
      clear_stim();
      len = $urandom_range(1, 6);
      LEN = 8'(len);
      for (int k = 0; k < 64; k++) vl_in[k] = (k >= 20) || ($urandom_range(0, 3) != 0);
      done = build_expect(len, -1);
      abort_at = -1;
      if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(2, done);
      if (abort_at >= 0) begin
        ab_in[abort_at] = 1;
        n = abort_at + 2;
      end else begin
        n = done + 1;
      end
      st_in[0] = 1;
      for (int k = 1; k < n; k++) st_in[k] = ($urandom_range(0, 1) != 0);
      done = build_expect(len, abort_at);
      drive_trace(n);
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL b2b run %0d len %0d abort %0d cycle %0d: got %b required %b",
                   r, len, abort_at, k, obs[k], exp_vec(k));
        end
      end
      n_cmp++;
      if (p_r !== exp_p(abort_at >= 0)) begin
        n_bad++; $display("FAIL b2b_p run %0d: got %0d required %0d", r, p_r, exp_p(abort_at >= 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_len4_stream();
    test_len3_gaps();
    test_len0();
    test_abort();
    test_zero_regs();
    test_rst_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
